// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 bus scheduler.
// Covers state encoding, the init command ROM and the command-length classification.
package lcd_pkg;

  localparam int TIMER_W = 20;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } state_t;

  localparam logic [7:0] CMD_FUNCTION_SET = 8'h38;
  localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0C;
  localparam logic [7:0] CMD_CLEAR        = 8'h01;
  localparam logic [7:0] CMD_HOME         = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT     = 8'h03;
  localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;

  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNCTION_SET;
      2'd1:    return CMD_DISPLAY_ON;
      2'd2:    return CMD_CLEAR;
      default: return CMD_ENTRY_MODE;
    endcase
  endfunction

  // Clear and home need the long post-byte wait; everything else is short.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == CMD_HOME_ALT);
  endfunction

  // Phase length n becomes a down-count load of n-1; zero is treated as one cycle.
  function automatic logic [TIMER_W-1:0] cycles_to_load(input int n);
    if (n <= 1) return '0;
    return TIMER_W'(n - 1);
  endfunction

endpackage

// File: rtl/lcd_bus_scheduler_if.sv
// Requester-side byte handshake between display writers and the LCD bus scheduler.
interface lcd_bus_scheduler_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   req_rs;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;

  modport master (output req, output req_rs, output req_data, input ack);
  modport slave  (input req, input req_rs, input req_data, output ack);
endinterface

// File: rtl/lcd_rr_arbiter.sv
// Round-robin arbiter: searches from the requester after the last granted one.
module lcd_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   index,
  output logic               valid
);

  logic [IDX_W-1:0] last;

  // NOTE: combinational logic uses blocking assignments with defaults first so no latch is inferred.
  always_comb begin
    int cand;
    grant = '0;
    index = '0;
    valid = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last) + k) % NUM_REQ;
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        index       = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)                last <= IDX_W'(NUM_REQ - 1);
    else if (advance && valid) last <= index;
  end

endmodule

// File: rtl/lcd_bus_scheduler.sv
// Owns the HD44780 bus: power-up wait, init ROM, then round-robin byte writes
// with setup / enable / hold / command-wait timing counted in clock cycles.
module lcd_bus_scheduler
  import lcd_pkg::*;
#(
  parameter int NUM_REQ           = 2,
  parameter int POWERUP_CYCLES    = 750000,
  parameter int SETUP_CYCLES      = 2,
  parameter int EN_HIGH_CYCLES    = 12,
  parameter int HOLD_CYCLES       = 2,
  parameter int CMD_WAIT_CYCLES   = 2000,
  parameter int CLEAR_WAIT_CYCLES = 82000
) (
  input  logic                  clock,
  input  logic                  reset,
  lcd_bus_scheduler_if.slave    bus,
  output logic                  init_done,
  output logic                  busy,
  output logic                  lcd_en,
  output logic                  lcd_rs,
  output logic                  lcd_rw,
  output logic [7:0]            lcd_data,
  output logic                  lcd_on
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [TIMER_W-1:0] POWERUP_LOAD = cycles_to_load(POWERUP_CYCLES);
  localparam logic [TIMER_W-1:0] SETUP_LOAD   = cycles_to_load(SETUP_CYCLES);
  localparam logic [TIMER_W-1:0] EN_LOAD      = cycles_to_load(EN_HIGH_CYCLES);
  localparam logic [TIMER_W-1:0] HOLD_LOAD    = cycles_to_load(HOLD_CYCLES);
  localparam logic [TIMER_W-1:0] CMD_LOAD     = cycles_to_load(CMD_WAIT_CYCLES);
  localparam logic [TIMER_W-1:0] CLEAR_LOAD   = cycles_to_load(CLEAR_WAIT_CYCLES);

  state_t               state;
  logic [TIMER_W-1:0]   timer;
  logic [1:0]           init_idx;
  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     index;
  logic                 valid;
  logic                 advance;

  assign advance = (state == ST_IDLE);
  assign lcd_rw  = 1'b0;
  assign lcd_on  = 1'b1;

  lcd_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arbiter (
    .clock   (clock),
    .reset   (reset),
    .req     (bus.req),
    .advance (advance),
    .grant   (grant),
    .index   (index),
    .valid   (valid)
  );

  // NOTE: all state and outputs are registered with non-blocking assignments.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_POWERUP;
      timer     <= '0;
      init_idx  <= '0;
      init_done <= 1'b0;
      busy      <= 1'b1;
      lcd_en    <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= '0;
      bus.ack   <= '0;
    end else begin
      bus.ack <= '0;
      case (state)
        // Power-up counts up from the reset value of zero.
        ST_POWERUP: begin
          if (timer == POWERUP_LOAD) state <= ST_INIT;
          else                       timer <= timer + 1'b1;
        end
        ST_INIT: begin
          lcd_rs   <= 1'b0;
          lcd_data <= init_rom(init_idx);
          timer    <= SETUP_LOAD;
          state    <= ST_SETUP;
        end
        ST_IDLE: begin
          if (valid) begin
            bus.ack  <= grant;
            lcd_rs   <= bus.req_rs[index];
            lcd_data <= bus.req_data[8*int'(index) +: 8];
            timer    <= SETUP_LOAD;
            busy     <= 1'b1;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (timer == '0) begin
            lcd_en <= 1'b1;
            timer  <= EN_LOAD;
            state  <= ST_PULSE;
          end else timer <= timer - 1'b1;
        end
        ST_PULSE: begin
          if (timer == '0) begin
            lcd_en <= 1'b0;
            timer  <= HOLD_LOAD;
            state  <= ST_HOLD;
          end else timer <= timer - 1'b1;
        end
        ST_HOLD: begin
          if (timer == '0) begin
            timer <= is_long_cmd(lcd_rs, lcd_data) ? CLEAR_LOAD : CMD_LOAD;
            state <= ST_WAIT;
          end else timer <= timer - 1'b1;
        end
        ST_WAIT: begin
          if (timer == '0) begin
            if (init_done || init_idx == 2'd3) begin
              init_done <= 1'b1;
              busy      <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              init_idx <= init_idx + 1'b1;
              state    <= ST_INIT;
            end
          end else timer <= timer - 1'b1;
        end
        default: state <= ST_POWERUP;
      endcase
    end
  end

endmodule
